ipm_unmask_serial: RTL and testbench
====================================

// Module: ipm_unmask_serial
// PURPOSE
//  Serial IPM decoder: recovers secret byte x from an IPM share vector (no RED redundancy) under public vector L.
//  x = s0 ^ XOR_{j=1..v-1} gf_mul(L_j, s_j), GF(2^8) modulo 0x11B; L_0 is implicitly 1.
//  Inverse end of the masking path: consumes shares produced or re-based by the encode and shift-public blocks.
//  One GF multiply per cycle, small area. Output is unmasked and is intended only for final result release.
// PARAMETERS
//  v  3  number of shares per byte; legal range 1..16
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    share/L pair offered
//  in_ready   out  1    block can accept a pair
//  share_in   in   v*8  share s_j at bits [(j+1)*8-1:j*8]; s_0 at [7:0]
//  L_in       in   v*8  public vector, same packing; bits [7:0] ignored (L_0 = 1)
//  out_valid  out  1    x_out is valid
//  out_ready  in   1    downstream accepts x_out
//  x_out      out  8    decoded byte
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, in_ready=1, out_valid=0, x_out=8'h00, counter=0, capture regs cleared.
//  FSM states: IDLE, ACC, DONE.
//  IDLE: in_ready=1. On in_valid&in_ready: latch share_in and L_in, acc<=s_0, j<=1.
//    Next state ACC if v>1; DONE directly if v==1.
//  ACC: in_ready=0. Each cycle acc<=acc^gf_mul(L_j,s_j) and j<=j+1.
//    Leave for DONE on the cycle that processes j=v-1. Exactly v-1 ACC cycles.
//  DONE: out_valid=1, x_out=acc, in_ready=0. On out_ready, return to IDLE with out_valid=0 next cycle.
//    x_out is stable while out_valid=1 and out_ready=0.
//  Latency: accept edge to out_valid high is v cycles for v>1, and 1 cycle for v==1.
//    Throughput: one byte per v+1 cycles with out_ready held high.
//  in_valid while busy is ignored; the source holds data until in_ready. No overlap or skid.
//  x_out is registered and keeps its last value in IDLE; only reset clears it.
//  Counter is $clog2(v)+1 bits wide, so there is no wrap for any legal v.
//  rst mid-ACC or in DONE aborts immediately: partial result discarded, out_valid=0 next cycle, no output produced.
//  rst and in_valid together: reset wins, nothing captured.
//  GF multiply is purely combinational: 8x8 carry-less product reduced by x^8+x^4+x^3+x+1.
//  Share operands are read only from the captured registers, never directly from share_in.
// STRUCTURE
//  Shared package ipm_pkg: GF_POLY=8'h1B, BYTE_W=8, fsm state typedef {IDLE,ACC,DONE}.
//  One sub-module: gf256_mul (a,b[7:0] -> p[7:0]). Use the same multiplier as the inner-product path so results match bit-exactly.
//  Captured share/L registers are indexed by j through a v-way byte mux feeding gf256_mul.
// TESTING
//  v=3, L={xx,03,02}, s={01,01,01} -> x_out=00 after 3 cycles; out_valid high for 1 cycle with out_ready=1.
//  v=3, L_1=CA, s_1=53, s_0=00, s_2=00, L_2=00 -> x_out=01 (AES inverse pair).
//  v=1, s_0=A5 -> x_out=A5 one cycle after accept; in_ready low exactly while busy.
//  Backpressure: out_ready=0 for 5 cycles in DONE -> x_out and out_valid held; in_ready=0 throughout.
//  rst pulsed in the 2nd ACC cycle -> out_valid never rises; next accepted vector decodes correctly.
//  Random: 1000 vectors, v=4, random L and shares, random stalls -> matches reference model, order preserved.

Source files
------------

// File: rtl/ipm_pkg.sv
// Shared definitions for the IPM unmasking path.
// GF(2^8) reduction constant and decoder FSM states.
package ipm_pkg;

  localparam int BYTE_W = 8;
  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ipm_unmask_serial_gf256_mul.sv
// Combinational GF(2^8) multiplier, modulus x^8+x^4+x^3+x+1.
// Same reduction as the inner-product path so results match bit-exactly.
module gf256_mul
  import ipm_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] p
);

  logic [14:0] prod;

  // Carry-less product, then fold the high bits back down by the modulus.
  always_comb begin
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ (15'(a) << i);
    end
    for (int i = 14; i >= 8; i--) begin
      if (prod[i]) prod = prod ^ (15'({1'b1, GF_POLY}) << (i - 8));
    end
  end

  assign p = prod[7:0];

endmodule

// File: rtl/ipm_unmask_serial.sv
// Serial IPM decoder: x = s0 ^ XOR_j gf_mul(L_j, s_j).
// One multiply per cycle over captured share/L registers.
module ipm_unmask_serial
  import ipm_pkg::*;
#(
  parameter int v = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [v*8-1:0] share_in,
  input  logic [v*8-1:0] L_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     x_out
);

  localparam int CW = $clog2(v) + 1;

  state_t state;
  state_t state_nx;

  logic [v*8-1:0] share_q;
  logic [v*8-1:0] l_q;
  logic [7:0]     acc;
  logic [CW-1:0]  j;
  logic [7:0]     s_sel;
  logic [7:0]     l_sel;
  logic [7:0]     prod;
  logic           accept;
  logic           last;

  assign accept = in_valid & in_ready;
  assign last   = (j == CW'(v - 1));

  // v-way byte mux selecting the operand pair for step j.
  always_comb begin
    s_sel = '0;
    l_sel = '0;
    for (int k = 0; k < v; k++) begin
      if (j == CW'(k)) begin
        s_sel = share_q[k*8 +: 8];
        l_sel = l_q[k*8 +: 8];
      end
    end
  end

  gf256_mul u_mul (
    .a (l_sel),
    .b (s_sel),
    .p (prod)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = (v > 1) ? ACC : DONE;
      end
      ACC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Capture operands and accumulate one product per ACC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      share_q <= '0;
      l_q     <= '0;
      acc     <= '0;
      j       <= '0;
    end else if (accept) begin
      share_q <= share_in;
      l_q     <= L_in;
      acc     <= share_in[7:0];
      j       <= CW'(1);
    end else if (state == ACC) begin
      acc <= acc ^ prod;
      j   <= j + CW'(1);
    end
  end

  assign x_out = acc;

endmodule

// File: tb/tb_ipm_unmask_serial.sv
// Bench for ipm_unmask_serial at v=3, v=1 and v=4.
// Expected bytes come from a GF(2^8) model queued per accepted vector.
module tb_ipm_unmask_serial;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        rst_a, iv_a, ir_a, ov_a, or_a;
  logic [23:0] sh_a, l_a;
  logic [7:0]  x_a;
  logic        rst_b, iv_b, ir_b, ov_b, or_b;
  logic [7:0]  sh_b, l_b;
  logic [7:0]  x_b;
  logic        rst_c, iv_c, ir_c, ov_c, or_c;
  logic [31:0] sh_c, l_c;
  logic [7:0]  x_c;

  ipm_unmask_serial #(.v(3)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_ready(ir_a),
    .share_in(sh_a), .L_in(l_a), .out_valid(ov_a),
    .out_ready(or_a), .x_out(x_a));
  ipm_unmask_serial #(.v(1)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_ready(ir_b),
    .share_in(sh_b), .L_in(l_b), .out_valid(ov_b),
    .out_ready(or_b), .x_out(x_b));
  ipm_unmask_serial #(.v(4)) dut_c (
    .clk(clk), .rst(rst_c), .in_valid(iv_c), .in_ready(ir_c),
    .share_in(sh_c), .L_in(l_c), .out_valid(ov_c),
    .out_ready(or_c), .x_out(x_c));

  int passed = 0;
  int total  = 0;
  int ncyc   = 0;
  bit rnd_stall = 0;

  logic [7:0] fq [3][0:63];
  int hd [3] = '{0, 0, 0};
  int tl [3] = '{0, 0, 0};
  bit busy [3] = '{0, 0, 0};
  bit prevv [3] = '{0, 0, 0};
  int acck [3] = '{0, 0, 0};

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Multiply by repeated doubling in the field.
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] decode(input int n,
                                        input logic [127:0] s,
                                        input logic [127:0] l);
    logic [7:0] x = s[7:0];
    for (int k = 1; k < n; k++) x ^= gmul(l[k*8 +: 8], s[k*8 +: 8]);
    return x;
  endfunction

  task automatic mon(input int id, input logic r, input logic iv,
                     input logic ir, input logic ov, input logic ordy,
                     input logic [7:0] x, input logic [127:0] s,
                     input logic [127:0] l, input int n);
    if (r) begin
      hd[id] = 0; tl[id] = 0; busy[id] = 0; prevv[id] = 0;
      return;
    end
    chk($sformatf("in_ready%0d", id), 32'(ir), 32'(!busy[id]));
    if (ov) begin
      if (hd[id] == tl[id]) begin
        chk($sformatf("spurious_out%0d", id), 32'(ov), 32'(0));
      end else begin
        chk($sformatf("x_out%0d", id), 32'(x), 32'(fq[id][hd[id]%64]));
        if (!prevv[id])
          chk($sformatf("latency%0d", id), 32'(ncyc - acck[id]), 32'(n));
        if (ordy) begin
          hd[id]++;
          busy[id] = 0;
        end
      end
    end
    if (iv && ir) begin
      busy[id] = 1;
      acck[id] = ncyc;
      fq[id][tl[id]%64] = decode(n, s, l);
      tl[id]++;
    end
    prevv[id] = ov;
  endtask

  // Single compare process checking all three instances each cycle.
  always @(negedge clk) begin
    ncyc++;
    mon(0, rst_a, iv_a, ir_a, ov_a, or_a, x_a, 128'(sh_a), 128'(l_a), 3);
    mon(1, rst_b, iv_b, ir_b, ov_b, or_b, x_b, 128'(sh_b), 128'(l_b), 1);
    mon(2, rst_c, iv_c, ir_c, ov_c, or_c, x_c, 128'(sh_c), 128'(l_c), 4);
  end

  // Random downstream stalls for the v=4 instance.
  always @(posedge clk) begin
    if (rnd_stall) #1 or_c = ($urandom_range(0, 3) != 0);
  end

  task automatic set_in(input int id, input logic vld,
                        input logic [127:0] s, input logic [127:0] l);
    case (id)
      0: begin iv_a = vld; sh_a = s[23:0]; l_a = l[23:0]; end
      1: begin iv_b = vld; sh_b = s[7:0];  l_b = l[7:0];  end
      default: begin iv_c = vld; sh_c = s[31:0]; l_c = l[31:0]; end
    endcase
  endtask

  function automatic logic rdy(input int id);
    case (id)
      0: return ir_a;
      1: return ir_b;
      default: return ir_c;
    endcase
  endfunction

  function automatic logic ovl(input int id);
    case (id)
      0: return ov_a;
      1: return ov_b;
      default: return ov_c;
    endcase
  endfunction

  // Offer one vector and hold it until accepted.
  task automatic send(input int id, input logic [127:0] s,
                      input logic [127:0] l);
    bit ok = 0;
    set_in(id, 1, s, l);
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (rdy(id)) begin ok = 1; break; end
    end
    if (!ok) chk($sformatf("accept_timeout%0d", id), 0, 1);
    @(posedge clk);
    #1 set_in(id, 0, '0, '0);
  endtask

  task automatic wait_out(input int id);
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ovl(id)) begin ok = 1; break; end
    end
    if (!ok) chk($sformatf("out_timeout%0d", id), 0, 1);
  endtask

  task automatic drain(input int id);
    bit ok = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (hd[id] == tl[id] && !busy[id]) begin ok = 1; break; end
    end
    if (!ok) chk($sformatf("drain_timeout%0d", id), 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] x0;
    rst_a = 1; rst_b = 1; rst_c = 1;
    iv_a = 0; iv_b = 0; iv_c = 0;
    sh_a = 0; sh_b = 0; sh_c = 0;
    l_a = 0; l_b = 0; l_c = 0;
    or_a = 1; or_b = 1; or_c = 1;
    repeat (2) @(posedge clk);
    #1 rst_a = 0; rst_b = 0; rst_c = 0;
    @(negedge clk);
    chk("rst_in_ready", {ir_a, ir_b, ir_c}, 3'b111);
    chk("rst_out_valid", {ov_a, ov_b, ov_c}, 3'b000);
    chk("rst_x_out", {x_a, x_b, x_c}, 24'h0);

    chk("model_aes_pair", gmul(8'hCA, 8'h53), 8'h01);
    chk("model_lin", decode(3, 128'h010101, 128'h030200), 8'h00);
    chk("model_v1", decode(1, 128'hA5, 128'h0), 8'hA5);

    @(posedge clk);
    #1 send(0, 128'h010101, 128'h030277);
    wait_out(0);
    chk("t1_x", x_a, 8'h00);
    @(negedge clk);
    chk("t1_pulse", ov_a, 1'b0);

    @(posedge clk);
    #1 send(0, 128'h005300, 128'h00CA00);
    wait_out(0);
    chk("t2_x", x_a, 8'h01);
    drain(0);
    chk("t2_x_held_idle", x_a, 8'h01);

    send(1, 128'hA5, 128'hFF);
    wait_out(1);
    chk("v1_x", x_b, 8'hA5);
    drain(1);

    or_a = 0;
    send(0, 128'h9C4E17, 128'h3B8D00);
    wait_out(0);
    x0 = 32'(x_a);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", ov_a, 1'b1);
      chk("bp_in_ready", ir_a, 1'b0);
      chk("bp_x", x_a, x0);
    end
    @(posedge clk);
    #1 or_a = 1;
    drain(0);

    send(2, 128'h11223344, 128'h55667788);
    @(posedge clk);
    #1 rst_c = 1;
    @(posedge clk);
    #1 rst_c = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_out", ov_c, 1'b0);
    end
    send(2, 128'hDEADBEEF, 128'h0BADF00D);
    drain(2);

    @(posedge clk);
    #1 rst_b = 1; iv_b = 1; sh_b = 8'h3C;
    @(posedge clk);
    #1 rst_b = 0; iv_b = 0;
    @(negedge clk);
    chk("rst_vs_valid_ready", ir_b, 1'b1);
    chk("rst_vs_valid_out", ov_b, 1'b0);

    rnd_stall = 1;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(2, 128'({$urandom}), 128'({$urandom}));
    end
    drain(2);
    rnd_stall = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
